// File: rtl/divider_pkg.sv
// Shared constants and helpers for the sequential signed divider.
package divider_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 32;

  localparam logic [1:0] DIV_IDLE   = 2'd0;
  localparam logic [1:0] DIV_DIVIDE = 2'd1;
  localparam logic [1:0] DIV_DONE   = 2'd2;

  // Bits needed to count 0..v-1 (minimum 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_restoring_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH:0]   dvs_mag,
  output logic [WIDTH-1:0] rem_next_c,
  output logic             q_bit_c
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Shift in the next dividend bit, trial-subtract, restore on underflow.
  // The kept difference is always below the divisor, so WIDTH bits suffice.
  always_comb begin
    shifted    = {rem, bit_in};
    q_bit_c    = (shifted >= dvs_mag);
    diff       = shifted[WIDTH-1:0] - dvs_mag[WIDTH-1:0];
    rem_next_c = q_bit_c ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider, one quotient bit per clock, truncating toward zero.
// Optional build macro SEQ_DIV_ZERO_FASTPATH_EN: divide-by-zero skips iteration.
module seq_signed_divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_sh_q, dvd_sh_d;
  logic [WIDTH:0]   dvs_mag_q, dvs_mag_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             q_neg_q, q_neg_d;
  logic             dz_q, dz_d;

  logic             busy_d, done_d, div_by_zero_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;

  logic [WIDTH-1:0] dvd_mag_c, dvs_mag_c;
  logic [WIDTH-1:0] step_rem_c;
  logic             step_q_c;
  logic             accept_c;
  logic [WIDTH-1:0] res_q_c, res_r_c;

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem        (rem_q),
    .bit_in     (dvd_sh_q[WIDTH-1]),
    .dvs_mag    (dvs_mag_q),
    .rem_next_c (step_rem_c),
    .q_bit_c    (step_q_c)
  );

  // Operand magnitudes and sign-corrected results.
  always_comb begin
    dvd_mag_c = dividend[WIDTH-1] ? WIDTH'(0) - dividend : dividend;
    dvs_mag_c = divisor[WIDTH-1]  ? WIDTH'(0) - divisor  : divisor;
    accept_c  = start && ((state_q == DIV_IDLE) || (state_q == DIV_DONE));
    res_q_c   = dz_q ? '1 : (q_neg_q ? WIDTH'(0) - quo_q : quo_q);
    res_r_c   = dvd_neg_q ? WIDTH'(0) - rem_q : rem_q;
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dvd_sh_d      = dvd_sh_q;
    dvs_mag_d     = dvs_mag_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvd_neg_d     = dvd_neg_q;
    q_neg_d       = q_neg_q;
    dz_d          = dz_q;
    done_d        = 1'b0;
    quotient_d    = quotient;
    remainder_d   = remainder;
    div_by_zero_d = div_by_zero;

    case (state_q)
      DIV_IDLE: ;
      DIV_DIVIDE: begin
        rem_d    = step_rem_c;
        quo_d    = {quo_q[WIDTH-2:0], step_q_c};
        dvd_sh_d = {dvd_sh_q[WIDTH-2:0], 1'b0};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        done_d        = 1'b1;
        quotient_d    = res_q_c;
        remainder_d   = res_r_c;
        div_by_zero_d = dz_q;
        state_d       = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase

    // Acceptance overrides the DONE->IDLE return for back-to-back divides.
    if (accept_c) begin
      state_d   = DIV_DIVIDE;
      cnt_d     = '0;
      dvd_sh_d  = dvd_mag_c;
      dvs_mag_d = {1'b0, dvs_mag_c};
      rem_d     = '0;
      quo_d     = '0;
      dvd_neg_d = dividend[WIDTH-1];
      q_neg_d   = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      dz_d      = (divisor == '0);
`ifdef SEQ_DIV_ZERO_FASTPATH_EN
      // Preload the remainder the iterations would have produced.
      if (divisor == '0) begin
        state_d = DIV_DONE;
        rem_d   = dvd_mag_c;
      end
`endif
    end

    busy_d = (state_d == DIV_DIVIDE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      dvd_sh_q    <= '0;
      dvs_mag_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvd_neg_q   <= 1'b0;
      q_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_sh_q    <= dvd_sh_d;
      dvs_mag_q   <= dvs_mag_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvd_neg_q   <= dvd_neg_d;
      q_neg_q     <= q_neg_d;
      dz_q        <= dz_d;
      busy        <= busy_d;
      done        <= done_d;
      quotient    <= quotient_d;
      remainder   <= remainder_d;
      div_by_zero <= div_by_zero_d;
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider (WIDTH = 32).
module tb_seq_signed_divider;

  localparam int unsigned W   = 32;
  localparam int          LAT = W + 1;
  localparam int          INT_MIN = int'(32'h8000_0000);
  localparam int          INT_MAX = int'(32'h7fff_ffff);
`ifdef SEQ_DIV_ZERO_FASTPATH_EN
  localparam bit FASTPATH = 1'b1;
`else
  localparam bit FASTPATH = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           e0;
    int           lat;
  } exp_t;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic exp_t make_exp(input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.dz  = dz;
    e.e0  = 0;
    e.lat = (dz && FASTPATH) ? 1 : LAT;
    return e;
  endfunction

  // Truncating reference built on the simulator's signed int arithmetic.
  function automatic exp_t model(input int x, input int y);
    if (y == 0)                       return make_exp('1, 32'(x), 1'b1);
    if (x == INT_MIN && y == -1)      return make_exp(32'(INT_MIN), '0, 1'b0);
    return make_exp(32'(x / y), 32'(x % y), 1'b0);
  endfunction

  // Result monitor: every done must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 64'(quotient), 64'(e.q));
        check("remainder", 64'(remainder), 64'(e.r));
        check("div_by_zero", 64'(div_by_zero), 64'(e.dz));
        check("latency", 64'(cyc - e.e0), 64'(e.lat));
      end
    end
  end

  task automatic issue(input int a, input int b, input exp_t e_in);
    exp_t e;
    e = e_in;
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'(a);
    divisor  = 32'(b);
    @(posedge clk);
    #1;
    e.e0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'(0));
    sb.delete();
    @(negedge clk);
  endtask

  task automatic busy_count(output int nb);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) nb++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   nb;
    bit   seen;
    exp_t e;

    vecs = '{'{7, -2, -3, 1}, '{-7, 2, -3, -1}, '{220, -11, -20, 0},
             '{-220, -11, 20, 0}, '{5, 7, 0, 5}, '{INT_MIN, -1, INT_MIN, 0},
             '{INT_MIN, INT_MAX, -1, -1}, '{INT_MAX, 1, INT_MAX, 0}};

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_quotient", 64'(quotient), 64'(0));
    check("rst_remainder", 64'(remainder), 64'(0));
    check("rst_dz", 64'(div_by_zero), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic divide with busy window measurement.
    issue(-10, 2, make_exp(32'(-5), '0, 1'b0));
    busy_count(nb);
    check("busy_cycles", 64'(nb), 64'(32));
    drain();

    // Sign, rounding and extreme operands.
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, make_exp(32'(vecs[i].q), 32'(vecs[i].r), 1'b0));
      drain();
    end

    // Divide by zero.
    issue(100, 0, make_exp('1, 32'(100), 1'b1));
    busy_count(nb);
    check("dz_busy_cycles", 64'(nb), FASTPATH ? 64'(0) : 64'(32));
    drain();
    issue(-37, 0, make_exp('1, 32'(-37), 1'b1));
    drain();

    // Random operands against the reference model.
    for (int i = 0; i < 20; i++) begin
      int a, b;
      a = int'($urandom);
      b = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) - 10 : int'($urandom);
      if (i % 3 == 0) a = a >>> $urandom_range(0, 28);
      issue(a, b, model(a, b));
      drain();
    end

    // start pulsed mid-DIVIDE with other operands must be ignored.
    issue(1000, 7, make_exp(32'(142), 32'(6), 1'b0));
    repeat (5) @(negedge clk);
    start    = 1'b1;
    dividend = 32'(55);
    divisor  = 32'(0);
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // start held through DONE gives a back-to-back divide.
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'(-99);
    divisor  = 32'(10);
    @(posedge clk);
    #1;
    e = make_exp(32'(-9), 32'(-9), 1'b0);
    e.e0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    dividend = 32'(77);
    divisor  = 32'(-8);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("b2b_first_done", 64'(seen), 64'(1));
    e = make_exp(32'(-9), 32'(5), 1'b0);
    e.e0 = cyc;
    sb.push_back(e);
    start = 1'b0;
    drain();

    // Asynchronous reset in the middle of an iteration.
    issue(123456, 789, model(123456, 789));
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_quotient", 64'(quotient), 64'(0));
    check("abort_remainder", 64'(remainder), 64'(0));
    check("abort_dz", 64'(div_by_zero), 64'(0));
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(12, 5, make_exp(32'(2), 32'(2), 1'b0));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
